// File: rtl/stopwatch_cpu_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// stopwatch_cpu_oci_dct_packer
//
// Producer side of the OCI data-compressed-trace channel. Trace codes from the
// CPU debug core are shifted into an accumulator. Each packet carries up to
// SLOTS codes, with the newest code in the low bits. A packet is handed to the
// trace consumer over a valid/ready output register. The block also runs the
// test_ending -> test_has_ended drain sequence.
//
// Handshake semantics, used on both sides:
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   A producer that raises valid holds its data stable until that transfer.
//   Ready may depend on valid, but valid never depends on ready.
//
// Ports:
//   clk, reset_n      single rising-edge clock; synchronous active-low reset
//   code_valid/code   incoming trace code
//   code_ready        code is taken when code_valid & code_ready
//   flush             pulse: emit the partial packet
//   test_ending       drain the remaining codes, then stop
//   dct_buffer        packed codes, newest in [CODE_W-1:0]
//   dct_count         number of valid codes in dct_buffer
//   pkt_valid         dct_buffer/dct_count are valid
//   pkt_ready         consumer takes the packet when pkt_valid & pkt_ready
//   test_has_ended    sticky end-of-test flag
//   overflow          one-cycle pulse: a code was offered after the test
//                     ended and was dropped
//   dbg_state         current FSM state (0 RUN, 1 DRAIN, 2 ENDED)
// ---------------------------------------------------------------------------
module stopwatch_cpu_oci_dct_packer #(
    parameter int CODE_W = 2,
    parameter int SLOTS  = 15,
    parameter int BUF_W  = 30,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    output logic              code_ready,
    input  logic              flush,
    input  logic              test_ending,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic              test_has_ended,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_ENDED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

    state_t             state;
    state_t             state_next;
    logic [BUF_W-1:0]   acc;
    logic [CNT_W-1:0]   acc_cnt;
    logic               flush_pend;

    logic               out_free;
    logic               acc_full;
    logic               acc_empty;
    logic               accept;
    logic               emit;

    // Next-state and handshake decode, all from registered state.
    always_comb begin
        state_next = state;
        out_free   = !pkt_valid || pkt_ready;
        acc_full   = (acc_cnt == FULL_CNT);
        acc_empty  = (acc_cnt == '0);
        // A full accumulator can still take a code when the packet leaves in
        // the same cycle; that code becomes slot 1 of the next packet.
        code_ready = (state == S_RUN) && (!acc_full || out_free);
        accept     = code_valid && code_ready;
        emit       = out_free &&
                     (acc_full || ((flush_pend || state == S_DRAIN) && !acc_empty));

        case (state)
            S_RUN:   if (test_ending) state_next = S_DRAIN;
            S_DRAIN: if (acc_empty && !pkt_valid) state_next = S_ENDED;
            S_ENDED: state_next = S_ENDED;
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator and flush request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc        <= '0;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (emit) begin
                if (accept) begin
                    acc     <= {{(BUF_W-CODE_W){1'b0}}, code};
                    acc_cnt <= CNT_W'(1);
                end else begin
                    acc     <= '0;
                    acc_cnt <= '0;
                end
            end else if (accept) begin
                acc     <= {acc[BUF_W-CODE_W-1:0], code};
                acc_cnt <= acc_cnt + CNT_W'(1);
            end

            // A flush against an empty accumulator lapses after one cycle
            // instead of producing an empty packet.
            if (emit) begin
                flush_pend <= 1'b0;
            end else begin
                flush_pend <= flush || (flush_pend && !acc_empty);
            end
        end
    end

    // Output packet register: loads on emit, holds while stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            pkt_valid  <= 1'b0;
        end else if (emit) begin
            dct_buffer <= acc;
            dct_count  <= acc_cnt;
            pkt_valid  <= 1'b1;
        end else if (pkt_ready) begin
            pkt_valid  <= 1'b0;
        end
    end

    // End-of-test flag and overflow pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            test_has_ended <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (state_next == S_ENDED) test_has_ended <= 1'b1;
            overflow <= code_valid && (state != S_RUN);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_stopwatch_cpu_oci_dct_packer.sv
module tb_stopwatch_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        code_valid;
  logic [1:0]  code;
  logic        code_ready;
  logic        flush;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        test_has_ended;
  logic        overflow;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  stopwatch_cpu_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .code_valid(code_valid), .code(code),
    .code_ready(code_ready), .flush(flush), .test_ending(test_ending),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .test_has_ended(test_has_ended),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Codes waiting to be packed, oldest first, plus the packet on offer.
  logic [1:0]  m_q[$];
  logic        m_valid, m_pend, m_drain, m_ended, m_ovf;
  logic [29:0] m_buf;
  logic [3:0]  m_cnt;
  logic [33:0] exp_q[$];   // {count, buffer} of every packet the model emits
  bit          cmp_en = 0;

  function automatic logic [29:0] pack_q();
    logic [29:0] v = '0;
    foreach (m_q[i]) v = v * 4 + 30'(m_q[i]);
    return v;
  endfunction

  function automatic logic m_ready();
    return !m_drain && !m_ended && (m_q.size() != 15 || !m_valid || pkt_ready);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_q.delete(); exp_q.delete();
      m_valid = 0; m_buf = '0; m_cnt = '0; m_pend = 0;
      m_drain = 0; m_ended = 0; m_ovf = 0;
    end else begin
      int n;
      logic free, running, take, emit, was_valid;
      n         = m_q.size();
      free      = !m_valid || pkt_ready;
      running   = !m_drain && !m_ended;
      take      = code_valid && m_ready();
      emit      = free && (n == 15 || ((m_pend || m_drain) && n > 0));
      was_valid = m_valid;
      m_ovf     = code_valid && !running;
      if (emit) begin
        m_buf = pack_q(); m_cnt = 4'(n); m_valid = 1;
        exp_q.push_back({m_cnt, m_buf});
        m_q.delete(); m_pend = 0;
      end else begin
        if (pkt_ready) m_valid = 0;
        if (flush) m_pend = 1;
        else if (n == 0) m_pend = 0;
      end
      if (take) m_q.push_back(code);
      if (running && test_ending) m_drain = 1;
      else if (m_drain && n == 0 && !was_valid) begin
        m_drain = 0; m_ended = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  int          pkt_count = 0;
  logic [29:0] last_buf;
  logic [3:0]  last_cnt;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("code_ready", code_ready, m_ready());
      chk("pkt_valid", pkt_valid, m_valid);
      chk("test_has_ended", test_has_ended, m_ended);
      chk("overflow", overflow, m_ovf);
      if (m_valid) begin
        chk("dct_buffer", dct_buffer, m_buf);
        chk("dct_count", dct_count, m_cnt);
      end
      if (reset_n && pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("sb_pkt", {dct_count, dct_buffer}, e);
        end
        last_buf = dct_buffer;
        last_cnt = dct_count;
        pkt_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one code and wait (bounded) until it is taken.
  task automatic send(input logic [1:0] c);
    code = c;
    code_valid = 1;
    for (int k = 0; k < 40; k++) begin
      if (code_ready) break;
      tick();
    end
    chk("send_ready", code_ready, 1);
    tick();
    code_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    reset_n = 0; code_valid = 0; code = '0; flush = 0;
    test_ending = 0; pkt_ready = 1;
    tick(); tick();
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_count", dct_count, 0);
    chk("rst_buffer", dct_buffer, 0);
    chk("rst_ended", test_has_ended, 0);
    cmp_en = 1;
    reset_n = 1;
    tick();

    // 15 back-to-back 01 codes
    base = pkt_count;
    for (int i = 0; i < 15; i++) send(2'b01);
    chk("t1_no_early_pkt", pkt_valid, 0);
    tick();
    chk("t1_valid", pkt_valid, 1);
    chk("t1_buf", dct_buffer, 30'h15555555);
    chk("t1_cnt", dct_count, 4'hF);
    tick();
    chk("t1_pkts", pkt_count - base, 1);

    // 3,2,1 then flush; then a flush with nothing pending
    base = pkt_count;
    send(2'd3); send(2'd2); send(2'd1);
    flush = 1; tick(); flush = 0;
    tick();
    chk("t2_buf", dct_buffer, 30'h39);
    chk("t2_cnt", dct_count, 4'd3);
    tick();
    flush = 1; tick(); flush = 0;
    tick(); tick(); tick();
    chk("t2_pkts", pkt_count - base, 1);

    // consumer stalled, 31 codes offered
    base = pkt_count;
    pkt_ready = 0;
    for (int i = 0; i < 30; i++) send(2'(i % 4));
    code = 2'd2; code_valid = 1;    // the 31st code (30 % 4)
    tick(); tick();
    chk("t3_stall_ready", code_ready, 0);
    chk("t3_held_buf", dct_buffer, 30'h06C6C6C6);
    chk("t3_held_cnt", dct_count, 4'hF);
    pkt_ready = 1;
    tick();
    code_valid = 0;
    chk("t3_first_hs", last_buf, 30'h06C6C6C6);
    chk("t3_second_buf", dct_buffer, 30'h31B1B1B1);
    chk("t3_second_cnt", dct_count, 4'hF);
    tick();
    flush = 1; tick(); flush = 0;
    tick();
    chk("t3_tail_buf", dct_buffer, 30'h2);
    chk("t3_tail_cnt", dct_count, 4'd1);
    tick();
    chk("t3_pkts", pkt_count - base, 3);

    // 15th code accepted as the held packet is released
    base = pkt_count;
    pkt_ready = 0;
    for (int i = 0; i < 29; i++) send(2'($urandom_range(0, 3)));
    pkt_ready = 1;
    send(2'($urandom_range(0, 3)));
    tick(); tick(); tick();
    chk("t6_pkts", pkt_count - base, 2);
    chk("t6_last_cnt", last_cnt, 4'hF);

    // 2,3 then test_ending
    base = pkt_count;
    send(2'd2); send(2'd3);
    test_ending = 1; tick(); test_ending = 0;
    tick();
    chk("t4_buf", dct_buffer, 30'hB);
    chk("t4_cnt", dct_count, 4'd2);
    for (int k = 0; k < 10; k++) begin
      if (test_has_ended) break;
      tick();
    end
    chk("t4_ended", test_has_ended, 1);
    tick(); tick();
    chk("t4_sticky", test_has_ended, 1);
    code_valid = 1; code = 2'd1; tick(); code_valid = 0;
    chk("t4_overflow", overflow, 1);
    tick();
    chk("t4_overflow_pulse", overflow, 0);
    chk("t4_pkts", pkt_count - base, 1);

    // reset mid-packet, then 15 codes of 11
    reset_n = 0; tick(); reset_n = 1;
    for (int i = 0; i < 5; i++) send(2'($urandom_range(0, 3)));
    reset_n = 0; tick(); reset_n = 1;
    chk("t5_valid", pkt_valid, 0);
    chk("t5_buf", dct_buffer, 0);
    chk("t5_cnt", dct_count, 0);
    chk("t5_ended", test_has_ended, 0);
    chk("t5_ovf", overflow, 0);
    base = pkt_count;
    tick(); tick();
    chk("t5_no_pkt", pkt_count - base, 0);
    for (int i = 0; i < 15; i++) send(2'b11);
    tick();
    chk("t5_buf_full", dct_buffer, 30'h3FFFFFFF);
    chk("t5_cnt_full", dct_count, 4'hF);
    tick(); tick();
    chk("t5_pkts", pkt_count - base, 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_cpu_oci_dct_packer.md
Name: stopwatch_cpu_oci_dct_packer

Overview:
Producer side of the OCI data-compressed-trace (DCT) channel. It accepts a stream of 2-bit trace codes from the CPU debug core and packs up to 15 of them into a 30-bit dct_buffer with a 4-bit dct_count. It delivers each packed word to the trace consumer over a valid/ready handshake and drives the test_ending/test_has_ended end-of-test sequence.

Parameters:
CODE_W, 2, width of one trace code
SLOTS, 15, codes per full packet
BUF_W, 30, packet width; must equal CODE_W*SLOTS
CNT_W, 4, count width; must hold SLOTS

Ports:
clk  input  1  single clock, all logic rising-edge
reset_n  input  1  synchronous active-low reset
code_valid  input  1  trace code offered
code  input  CODE_W  trace code value
code_ready  output  1  code accepted this cycle when code_valid & code_ready
flush  input  1  single-cycle pulse: emit partial packet
test_ending  input  1  level or pulse: drain and stop
dct_buffer  output  BUF_W  packed codes, newest in [1:0]
dct_count  output  CNT_W  number of valid codes in dct_buffer (1..15)
pkt_valid  output  1  dct_buffer/dct_count valid
pkt_ready  input  1  consumer takes packet when pkt_valid & pkt_ready
test_has_ended  output  1  sticky end-of-test flag
overflow  output  1  one-cycle pulse: code offered after end-of-test, discarded

Behaviour:
- Reset (reset_n=0 at a clk edge): acc, acc_cnt, dct_buffer, dct_count, pkt_valid, flush_pend, test_has_ended and overflow all go to 0; state goes to RUN. Reset mid-packet discards all partial and held data.
- Internal accumulator acc[BUF_W-1:0] and acc_cnt[CNT_W-1:0]. accept = code_valid & code_ready. On accept: acc <= {acc[BUF_W-3:0], code}, acc_cnt+1. Unused upper slots read 0.
- out_free = !pkt_valid | pkt_ready.
- emit = out_free & (acc_cnt==SLOTS | ((flush_pend | state==DRAIN) & acc_cnt!=0)), evaluated on registered state.
- On emit: dct_buffer<=acc, dct_count<=acc_cnt, pkt_valid<=1, flush_pend<=0.
- Accumulator after emit: if accept in the same cycle, acc<={0,code} and acc_cnt<=1; otherwise acc and acc_cnt clear to 0.
- pkt_valid falls after a handshake when no emit happens in that cycle. Output registers hold stable while pkt_valid & !pkt_ready.
- Latency: the packet appears one cycle after the 15th code is accepted, when the output is free. Back-to-back codes sustain full throughput with pkt_ready=1.
- code_ready = (state==RUN) & (acc_cnt!=SLOTS | out_free). The accumulator stalls only when full and the output is held.
- flush: sets flush_pend. If acc_cnt==0, flush_pend clears next cycle and no empty packet is emitted. A code accepted in the emit cycle goes to the next packet.
- State machine:
  - RUN: test_ending=1 -> DRAIN.
  - DRAIN: code_ready=0; partial packet emitted via emit. When acc_cnt==0 & !pkt_valid -> ENDED.
  - ENDED: test_has_ended=1 (registered, asserts on entry), sticky until reset; code_ready=0.
- overflow = registered pulse, 1 in the cycle after code_valid=1 while state is DRAIN or ENDED. That code is dropped.
- Simultaneous flush and test_ending: test_ending dominates; behaviour is identical.
- Simultaneous accept and emit at acc_cnt==SLOTS: legal. The old 15 codes go out and the new code becomes slot 1.

Test Plan:
- 15 back-to-back codes of 2'b01, pkt_ready=1 -> exactly one packet one cycle after the 15th accept: dct_buffer=30'h15555555, dct_count=4'hF; code_ready stays 1 throughout.
- Codes 3,2,1 then flush pulse -> one packet: dct_buffer=30'h39, dct_count=3. A further flush with empty acc -> no packet.
- pkt_ready=0 with 31 codes offered (0,1,2,3 repeating):
  - first packet held stable; the second 15 codes fill acc; code_ready=0 with code 31 pending.
  - raise pkt_ready -> first handshake, second packet presented next cycle (count 15), code 31 accepted as slot 1.
- Codes 2,3 then test_ending=1 -> packet dct_buffer=30'hB, dct_count=2. Once consumed, test_has_ended=1 the following cycle and stays 1. A later code_valid pulse -> overflow=1 for one cycle, no packet.
- 5 codes accepted, then reset_n=0 for one cycle -> all outputs 0, no packet. Next 15 codes of 2'b11 -> dct_buffer=30'h3FFFFFFF, count 15.
- 15th code accepted in the same cycle a held packet is released (pkt_ready=1) -> held packet handshakes; the new full packet is valid next cycle with no lost or duplicated codes.
